// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I opcodes, NOP encoding, field positions and fetch state enum
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} fetch_state_e;
endpackage

// File: rtl/if_skid_buffer.sv
// if_skid_buffer: one-entry (pc, instr) holding register for fetch stall
// Ports: clk, rst; i_load captures i_pc/i_instr; i_unload empties; i_flush clears;
//        o_full flags a held entry presented on o_pc/o_instr.
module if_skid_buffer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_unload,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output logic            o_full,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr
);
  logic            r_full;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  always_ff @(posedge clk) begin
    if (rst || i_flush) r_full <= 1'b0;
    else if (i_load) r_full <= 1'b1;
    else if (i_unload) r_full <= 1'b0;
  end
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end
  assign o_full  = r_full;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: RV32I fetch stage with PC, 1-cycle imem interface, skid buffer and redirect
// Ports: clk, rst (sync, active-high); imem_en/imem_addr/imem_rdata to instruction memory;
//        stall from decode; redirect_valid/redirect_pc from execute;
//        if_* registered instruction and decoded fields; fetch_err sticky misaligned redirect.
module instr_fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [XLEN-1:0]    if_pc,
  output logic [31:0]        if_instr,
  output logic [6:0]         if_opcode,
  output logic [2:0]         if_funct3,
  output logic [6:0]         if_funct7,
  output logic [4:0]         if_rd,
  output logic [4:0]         if_rs1,
  output logic [4:0]         if_rs2,
  output logic               fetch_err
);
  fetch_state_e    r_state, w_state_nx;
  logic [XLEN-1:0] r_pc, r_pend_pc, r_if_pc, w_skid_pc;
  logic [31:0]     r_if_instr, w_skid_instr;
  logic            r_pend, r_if_valid, r_fetch_err;
  logic            w_issue, w_redir_ok, w_misalign, w_skid_full;
  assign w_redir_ok = redirect_valid && redirect_pc[1:0] == 2'b00 && r_state != S_HALT;
  assign w_misalign = redirect_valid && redirect_pc[1:0] != 2'b00 && r_state != S_HALT;
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_BOOT;
    else r_state <= w_state_nx;
  end
  // Boot lasts exactly one cycle; halt is absorbing until reset.
  always_comb begin
    w_issue    = r_state == S_RUN && !stall && !w_skid_full && !redirect_valid;
    w_state_nx = (r_state == S_HALT || w_misalign) ? S_HALT : S_RUN;
  end
  // A response arriving under stall parks in the skid; the skid drains before any new issue.
  if_skid_buffer #(.XLEN(XLEN)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_load   (r_pend && stall && !redirect_valid),
    .i_unload (!stall && !redirect_valid),
    .i_flush  (redirect_valid),
    .i_pc     (r_pend_pc),
    .i_instr  (imem_rdata),
    .o_full   (w_skid_full),
    .o_pc     (w_skid_pc),
    .o_instr  (w_skid_instr)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_pend      <= 1'b0;
      r_pend_pc   <= '0;
      r_if_valid  <= 1'b0;
      r_if_pc     <= '0;
      r_if_instr  <= NOP;
      r_fetch_err <= 1'b0;
    end else begin
      r_pend <= w_issue;
      if (w_issue) r_pend_pc <= r_pc;
      if (w_redir_ok) r_pc <= redirect_pc;
      else if (w_issue) r_pc <= r_pc + XLEN'(4);
      if (w_misalign) r_fetch_err <= 1'b1;
      // Redirect kills the in-flight response even while decode is stalled.
      if (redirect_valid || r_state == S_HALT) r_if_valid <= 1'b0;
      else if (!stall) begin
        if (w_skid_full) begin
          r_if_valid <= 1'b1;
          r_if_pc    <= w_skid_pc;
          r_if_instr <= w_skid_instr;
        end else if (r_pend) begin
          r_if_valid <= 1'b1;
          r_if_pc    <= r_pend_pc;
          r_if_instr <= imem_rdata;
        end else r_if_valid <= 1'b0;
      end
    end
  end
  assign imem_en   = w_issue;
  assign imem_addr = r_pc[IMEM_AW+1:2];
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;
  assign if_opcode = r_if_instr[OPC_LSB +: 7];
  assign if_rd     = r_if_instr[RD_LSB +: 5];
  assign if_funct3 = r_if_instr[F3_LSB +: 3];
  assign if_rs1    = r_if_instr[RS1_LSB +: 5];
  assign if_rs2    = r_if_instr[RS2_LSB +: 5];
  assign if_funct7 = r_if_instr[F7_LSB +: 7];
  assign fetch_err = r_fetch_err;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: queue-based fetch model with per-cycle compare plus directed literal checks
module tb_instr_fetch_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1, stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_en, if_valid, fetch_err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = '0, if_pc, if_instr;
  logic [6:0]  if_opcode, if_funct7;
  logic [2:0]  if_funct3;
  logic [4:0]  if_rd, if_rs1, if_rs2;
  always #5 clk = ~clk;
  instr_fetch_stage dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_opcode(if_opcode),
    .if_funct3(if_funct3), .if_funct7(if_funct7), .if_rd(if_rd), .if_rs1(if_rs1),
    .if_rs2(if_rs2), .fetch_err(fetch_err)
  );
  logic [31:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {i[11:0], 20'h00013};
    mem[0] = 32'h003100B3;
    mem[1] = 32'h40418133;
    mem[2] = 32'h00108093;
    mem[3] = 32'h0000A283;
  end
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  bit          m_started = 0, m_boot, m_halt, m_err, m_ov, m_iss;
  logic [31:0] m_pc, m_opc;
  logic [31:0] m_inflight[$], m_held[$];
  function automatic bit m_en();
    return !m_halt && !m_boot && !stall && m_held.size() == 0 && !redirect_valid;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_started = 1; m_boot = 1; m_halt = 0; m_err = 0; m_ov = 0;
      m_pc = 32'h0; m_opc = 32'h0;
      m_inflight.delete(); m_held.delete();
    end else if (m_started) begin
      m_iss = m_en();
      if (m_halt) m_ov = 0;
      else if (redirect_valid) begin
        if (redirect_pc[1:0] != 2'b00) begin m_err = 1; m_halt = 1; end
        else m_pc = redirect_pc;
        m_ov = 0; m_inflight.delete(); m_held.delete();
      end else begin
        if (stall) begin
          if (m_inflight.size() > 0) m_held.push_back(m_inflight[0]);
        end else if (m_held.size() > 0) begin m_ov = 1; m_opc = m_held.pop_front(); end
        else if (m_inflight.size() > 0) begin m_ov = 1; m_opc = m_inflight[0]; end
        else m_ov = 0;
        m_inflight.delete();
        if (m_iss) begin m_inflight.push_back(m_pc); m_pc = m_pc + 32'd4; end
      end
      m_boot = 0;
    end
  end
  always @(negedge clk) begin
    if (m_started && !rst) begin
      chk("fetch_err", 32'(fetch_err), 32'(m_err));
      chk("if_valid", 32'(if_valid), 32'(m_ov));
      if (m_ov) begin
        chk("if_pc", if_pc, m_opc);
        chk("if_instr", if_instr, mem[m_opc[11:2]]);
        chk("fields", {if_funct7, if_rs2, if_rs1, if_funct3, if_rd, if_opcode}, mem[m_opc[11:2]]);
      end
      chk("imem_en", 32'(imem_en), 32'(m_en()));
      if (m_en()) chk("imem_addr", 32'(imem_addr), 32'(m_pc[11:2]));
    end
  end
  task automatic cyc(input bit r, input bit s, input bit rv, input logic [31:0] rp);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    @(posedge clk); #1;
  endtask
  logic [31:0] held_pc;
  initial begin
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h13);
    chk("rst_err", 32'(fetch_err), 0);
    cyc(0, 0, 0, 0);
    chk("boot_en", 32'(imem_en), 1); chk("addr0", 32'(imem_addr), 0);
    cyc(0, 0, 0, 0);
    chk("addr1", 32'(imem_addr), 1); chk("lat_valid", 32'(if_valid), 0);
    cyc(0, 0, 0, 0);
    chk("addr2", 32'(imem_addr), 2); chk("pc0", if_pc, 32'h0); chk("op0", 32'(if_opcode), 32'h33);
    cyc(0, 0, 0, 0);
    chk("addr3", 32'(imem_addr), 3); chk("pc4", if_pc, 32'h4); chk("op1", 32'(if_opcode), 32'h33);
    cyc(0, 0, 0, 0);
    chk("pc8", if_pc, 32'h8); chk("op2", 32'(if_opcode), 32'h13);
    cyc(0, 0, 0, 0);
    chk("pcC", if_pc, 32'hC); chk("op3", 32'(if_opcode), 32'h03);
    held_pc = if_pc;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0);
      chk("stall_pc", if_pc, held_pc);
    end
    cyc(0, 0, 0, 0);
    chk("skid_out", if_pc, 32'h10);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("after_skid", if_pc, 32'h14);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h40);
    chk("redir_v0", 32'(if_valid), 0);
    cyc(0, 0, 0, 0);
    chk("redir_v1", 32'(if_valid), 0);
    cyc(0, 0, 0, 0);
    chk("redir_pc", if_pc, 32'h40); chk("redir_v2", 32'(if_valid), 1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h100);
    chk("rs_drop", 32'(if_valid), 0);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("rs_pc", if_pc, 32'h100);
    cyc(0, 0, 1, 32'h1000_0040);
    chk("hi_addr", 32'(imem_addr), 32'h10);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("hi_pc", if_pc, 32'h1000_0040);
    cyc(0, 0, 1, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("wrap_pc", if_pc, 32'h0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("rst_skid_pc", if_pc, 32'h0); chk("rst_skid_v", 32'(if_valid), 1);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h42);
    chk("mis_err", 32'(fetch_err), 1); chk("mis_valid", 32'(if_valid), 0);
    chk("mis_en", 32'(imem_en), 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("halt_en", 32'(imem_en), 0); chk("halt_valid", 32'(if_valid), 0);
    cyc(0, 0, 1, 32'h80); cyc(0, 0, 0, 0);
    chk("halt_sticky", 32'(fetch_err), 1); chk("halt_en2", 32'(imem_en), 0);
    cyc(1, 0, 0, 0);
    chk("err_clr", 32'(fetch_err), 0);
    cyc(0, 0, 0, 0);
    chk("refetch_en", 32'(imem_en), 1); chk("refetch_addr", 32'(imem_addr), 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
